// File: rtl/regfile_preload_pkg.sv
// Shared definitions for the regfile preloader: state encoding and the
// architectural constants of the regfile it sits in front of.
package regfile_preload_pkg;

   localparam int NUM_REGS = 32;
   localparam int REG_W    = 5;
   localparam int DATA_W   = 32;
   localparam int CNT_W    = 6;
   localparam int R0       = 0;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      CHECK = 3'd2,
      DONE  = 3'd3,
      ERR   = 3'd4
   } state_t;

endpackage

// File: rtl/regfile_preload_wr_mux.sv
// Two-way port select: the idle side (processor) or the preload side.
// Used for the regfile write port and for the readRegA index hijack.
module preload_wr_mux #(
   parameter int W = 38
) (
   input  logic         sel,
   input  logic [W-1:0] idle_in,
   input  logic [W-1:0] load_in,
   output logic [W-1:0] out
);

   // Pure combinational select so idle passthrough has zero latency
   always_comb begin
      out = sel ? load_in : idle_in;
   end

endmodule

// File: rtl/regfile_preload.sv
// Regfile preloader: passes processor writes through while idle, and on a
// start pulse holds the processor and streams (register, value) pairs into
// the regfile write port. Writes to r0 are dropped and flagged.
// Optional read-back verification of every write: REGFILE_PRELOAD_VERIFY_EN.
module regfile_preload
   import regfile_preload_pkg::*;
#(
   parameter int NUM_REGS = regfile_preload_pkg::NUM_REGS,
   parameter int REG_W    = regfile_preload_pkg::REG_W,
   parameter int DATA_W   = regfile_preload_pkg::DATA_W,
   parameter int CNT_W    = regfile_preload_pkg::CNT_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [REG_W-1:0]  load_reg,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   input  logic              proc_we,
   input  logic [REG_W-1:0]  proc_wr_reg,
   input  logic [DATA_W-1:0] proc_wr_data,
   output logic              rf_we,
   output logic [REG_W-1:0]  rf_wr_reg,
   output logic [DATA_W-1:0] rf_wr_data,
   output logic              proc_hold,
   output logic              busy,
   output logic              done,
   output logic              err_r0,
   output logic [CNT_W-1:0]  count
`ifdef REGFILE_PRELOAD_VERIFY_EN
   ,
   output logic              rd_sel,
   output logic [REG_W-1:0]  rf_rd_reg,
   input  logic [DATA_W-1:0] rf_rd_data,
   output logic              verify_err
`endif
);

   localparam int WB_W = 1 + REG_W + DATA_W;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t            state;
   state_t            state_next;
   logic              handshake;
   logic              target_r0;
   logic              target_ok;
   logic              load_we;
   logic              port_sel;
   logic [WB_W-1:0]   wr_bus;

   assign handshake = load_valid & load_ready;
   assign target_r0 = (load_reg == REG_W'(R0));
   // Indices beyond the implemented registers are never committed
   assign target_ok = !target_r0 && (32'(load_reg) < NUM_REGS);
   assign load_we   = handshake & target_ok;

`ifdef REGFILE_PRELOAD_VERIFY_EN
   logic [REG_W-1:0]  lat_reg;
   logic [DATA_W-1:0] lat_data;
   logic              lat_last;

   // Capture the committed word so CHECK can read it back one cycle later
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lat_reg  <= '0;
         lat_data <= '0;
         lat_last <= 1'b0;
      end else if (load_we) begin
         lat_reg  <= load_reg;
         lat_data <= load_data;
         lat_last <= load_last;
      end
   end

   preload_wr_mux #(.W(REG_W)) u_rd_mux (
      .sel     (rd_sel),
      .idle_in ({REG_W{1'b0}}),
      .load_in (lat_reg),
      .out     (rf_rd_reg)
   );
`endif

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = LOAD;
         LOAD: begin
            if (handshake) begin
`ifdef REGFILE_PRELOAD_VERIFY_EN
               if (load_we)        state_next = CHECK;
               else if (load_last) state_next = DONE;
`else
               if (load_last)      state_next = DONE;
`endif
            end
         end
`ifdef REGFILE_PRELOAD_VERIFY_EN
         CHECK: begin
            if (rf_rd_data != lat_data) state_next = ERR;
            else if (lat_last)          state_next = DONE;
            else                        state_next = LOAD;
         end
         ERR:  state_next = ERR;
`endif
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Moore outputs decoded from the current state
   always_comb begin
      load_ready = (state == LOAD);
      proc_hold  = (state != IDLE);
      busy       = (state != IDLE) && (state != DONE);
      done       = (state == DONE);
      port_sel   = (state != IDLE);
`ifdef REGFILE_PRELOAD_VERIFY_EN
      rd_sel     = (state == CHECK);
      verify_err = (state == ERR);
`endif
   end

   // Words accepted in this preload, including dropped r0 words; saturates
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (state == IDLE && start) begin
         count <= '0;
      end else if (handshake && count != CNT_MAX) begin
         count <= count + CNT_W'(1);
      end
   end

   // Sticky r0 flag, cleared only when a new preload begins
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         err_r0 <= 1'b0;
      end else if (state == IDLE && start) begin
         err_r0 <= 1'b0;
      end else if (handshake && target_r0) begin
         err_r0 <= 1'b1;
      end
   end

   preload_wr_mux #(.W(WB_W)) u_wr_mux (
      .sel     (port_sel),
      .idle_in ({proc_we, proc_wr_reg, proc_wr_data}),
      .load_in ({load_we, load_reg, load_data}),
      .out     (wr_bus)
   );

   assign rf_we      = wr_bus[WB_W-1];
   assign rf_wr_reg  = wr_bus[WB_W-2 -: REG_W];
   assign rf_wr_data = wr_bus[DATA_W-1:0];

endmodule

// File: tb/tb_regfile_preload.sv
// Directed bench for regfile_preload with a behavioural regfile model.
// Also builds with REGFILE_PRELOAD_VERIFY_EN to exercise read-back checking.
module tb_regfile_preload;
   import regfile_preload_pkg::*;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              load_valid = 1'b0;
   logic              load_ready;
   logic [REG_W-1:0]  load_reg = '0;
   logic [DATA_W-1:0] load_data = '0;
   logic              load_last = 1'b0;
   logic              proc_we = 1'b0;
   logic [REG_W-1:0]  proc_wr_reg = '0;
   logic [DATA_W-1:0] proc_wr_data = '0;
   logic              rf_we;
   logic [REG_W-1:0]  rf_wr_reg;
   logic [DATA_W-1:0] rf_wr_data;
   logic              proc_hold;
   logic              busy;
   logic              done;
   logic              err_r0;
   logic [CNT_W-1:0]  count;
`ifdef REGFILE_PRELOAD_VERIFY_EN
   logic              rd_sel;
   logic [REG_W-1:0]  rf_rd_reg;
   logic [DATA_W-1:0] rf_rd_data;
   logic              verify_err;
   logic              corrupt = 1'b0;
`endif

   logic              clear_model = 1'b1;
   logic [DATA_W-1:0] regs [NUM_REGS];
   int                checks = 0;
   int                passes = 0;
   int                stall_cycles = 0;

   always #5 clock = ~clock;

   regfile_preload dut (
      .clock        (clock),
      .reset        (reset),
      .start        (start),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .load_reg     (load_reg),
      .load_data    (load_data),
      .load_last    (load_last),
      .proc_we      (proc_we),
      .proc_wr_reg  (proc_wr_reg),
      .proc_wr_data (proc_wr_data),
      .rf_we        (rf_we),
      .rf_wr_reg    (rf_wr_reg),
      .rf_wr_data   (rf_wr_data),
      .proc_hold    (proc_hold),
      .busy         (busy),
      .done         (done),
      .err_r0       (err_r0),
      .count        (count)
`ifdef REGFILE_PRELOAD_VERIFY_EN
      ,
      .rd_sel       (rd_sel),
      .rf_rd_reg    (rf_rd_reg),
      .rf_rd_data   (rf_rd_data),
      .verify_err   (verify_err)
`endif
   );

   // Raw regfile model: records every committed write, r0 included
   always @(posedge clock) begin
      if (clear_model) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (rf_we) begin
         regs[rf_wr_reg] <= rf_wr_data;
      end
   end

`ifdef REGFILE_PRELOAD_VERIFY_EN
   assign rf_rd_data = regs[rf_rd_reg] ^ {DATA_W{corrupt}};
`endif

   // Pulse start for one cycle; called and returns at a falling edge
   task automatic start_preload();
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      #1;
   endtask

   // Present one word and hold it until accepted; returns at a falling edge
   task automatic send_word(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d,
                            input logic l);
      int waits;
      waits = 0;
      load_valid = 1'b1;
      load_reg   = r;
      load_data  = d;
      load_last  = l;
      #1;
      while (!load_ready && waits < 10) begin
         @(negedge clock);
         #1;
         waits++;
      end
      stall_cycles += waits;
      if (!load_ready) begin
         checks++;
         $display("[TB] FAIL handshake_timeout reg=%0d load_ready=%b required 1", r, load_ready);
      end else begin
         @(negedge clock);
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   // Wait a bounded number of cycles for the done pulse
   task automatic wait_done(input string name);
      int n;
      n = 0;
      #1;
      while (!done && n < 6) begin
         @(negedge clock);
         #1;
         n++;
      end
      checks++;
      if (done !== 1'b1) $display("[TB] FAIL %s_done got %b required 1", name, done);
      else passes++;
   endtask

   task automatic test_reset();
      checks++;
      if ({load_ready, proc_hold, busy, done, err_r0} !== 5'b0)
         $display("[TB] FAIL reset_flags got %b required 00000",
                  {load_ready, proc_hold, busy, done, err_r0});
      else passes++;
      checks++;
      if (count !== '0) $display("[TB] FAIL reset_count got %0d required 0", count);
      else passes++;
   endtask

   task automatic test_idle_passthrough();
      proc_we = 1'b1; proc_wr_reg = 5'd7; proc_wr_data = 32'h1234;
      #1;
      checks++;
      if ({rf_we, rf_wr_reg, rf_wr_data} !== {1'b1, 5'd7, 32'h1234})
         $display("[TB] FAIL idle_pass got we=%b reg=%0d data=%h required 1/7/1234",
                  rf_we, rf_wr_reg, rf_wr_data);
      else passes++;
      checks++;
      if (load_ready !== 1'b0) $display("[TB] FAIL idle_ready got %b required 0", load_ready);
      else passes++;
      @(negedge clock);
      proc_we = 1'b0;
      checks++;
      if (regs[7] !== 32'h1234) $display("[TB] FAIL idle_reg7 got %h required 1234", regs[7]);
      else passes++;
   endtask

   task automatic test_back_to_back();
      checks++;
      if (proc_hold !== 1'b0) $display("[TB] FAIL b2b_hold_pre got %b required 0", proc_hold);
      else passes++;
      start_preload();
      checks++;
      if ({proc_hold, busy, load_ready} !== 3'b111)
         $display("[TB] FAIL b2b_load_flags got %b required 111", {proc_hold, busy, load_ready});
      else passes++;
      send_word(5'd1, 32'd5, 1'b0);
      send_word(5'd2, 32'hFFFF_FFFD, 1'b0);
      send_word(5'd31, 32'hDEAD_BEEF, 1'b1);
`ifndef REGFILE_PRELOAD_VERIFY_EN
      checks++;
      if (stall_cycles !== 0) $display("[TB] FAIL b2b_stalls got %0d required 0", stall_cycles);
      else passes++;
`endif
      wait_done("b2b");
      checks++;
      if ({count, proc_hold, busy} !== {6'd3, 1'b1, 1'b0})
         $display("[TB] FAIL b2b_done_state got count=%0d hold=%b busy=%b required 3/1/0",
                  count, proc_hold, busy);
      else passes++;
      @(negedge clock);
      #1;
      checks++;
      if ({done, proc_hold} !== 2'b00)
         $display("[TB] FAIL b2b_after_done got %b required 00", {done, proc_hold});
      else passes++;
      checks++;
      if ({regs[1], regs[2], regs[31]} !== {32'd5, 32'hFFFF_FFFD, 32'hDEAD_BEEF})
         $display("[TB] FAIL b2b_regs got %h %h %h required 5 fffffffd deadbeef",
                  regs[1], regs[2], regs[31]);
      else passes++;
   endtask

   task automatic test_r0_word();
      @(negedge clock);
      start_preload();
      send_word(5'd0, 32'd9, 1'b0);
      send_word(5'd4, 32'd4, 1'b1);
      wait_done("r0");
      checks++;
      if ({err_r0, count} !== {1'b1, 6'd2})
         $display("[TB] FAIL r0_flags got err=%b count=%0d required 1/2", err_r0, count);
      else passes++;
      checks++;
      if ({regs[0], regs[4]} !== {32'd0, 32'd4})
         $display("[TB] FAIL r0_regs got r0=%h r4=%h required 0/4", regs[0], regs[4]);
      else passes++;
      @(negedge clock);
   endtask

   task automatic test_proc_write_dropped();
      start_preload();
      checks++;
      if (err_r0 !== 1'b0) $display("[TB] FAIL pw_err_clear got %b required 0", err_r0);
      else passes++;
      send_word(5'd4, 32'd100, 1'b0);
      proc_we = 1'b1; proc_wr_reg = 5'd4; proc_wr_data = 32'd77;
      send_word(5'd5, 32'd6, 1'b1);
      wait_done("pw");
      proc_we = 1'b0;
      @(negedge clock);
      checks++;
      if ({regs[4], regs[5]} !== {32'd100, 32'd6})
         $display("[TB] FAIL pw_regs got r4=%0d r5=%0d required 100/6", regs[4], regs[5]);
      else passes++;
   endtask

   task automatic test_reset_mid_stream();
      start_preload();
      send_word(5'd10, 32'h111, 1'b0);
      load_valid = 1'b1; load_reg = 5'd11; load_data = 32'h222;
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({proc_hold, load_ready, busy, done} !== 4'b0000 || count !== '0)
         $display("[TB] FAIL rst_mid got flags=%b count=%0d required 0000/0",
                  {proc_hold, load_ready, busy, done}, count);
      else passes++;
      load_valid = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks++;
      if ({regs[10], regs[11]} !== {32'h111, 32'h0})
         $display("[TB] FAIL rst_regs got r10=%h r11=%h required 111/0", regs[10], regs[11]);
      else passes++;
      start_preload();
      checks++;
      if (count !== '0) $display("[TB] FAIL rst_restart_count got %0d required 0", count);
      else passes++;
      send_word(5'd12, 32'hABC, 1'b1);
      wait_done("rst");
      checks++;
      if (count !== 6'd1) $display("[TB] FAIL rst_reload_count got %0d required 1", count);
      else passes++;
      @(negedge clock);
      checks++;
      if (regs[12] !== 32'hABC) $display("[TB] FAIL rst_reload_reg got %h required abc", regs[12]);
      else passes++;
   endtask

`ifdef REGFILE_PRELOAD_VERIFY_EN
   task automatic test_verify_mismatch();
      start_preload();
      send_word(5'd20, 32'd1, 1'b0);
      corrupt = 1'b1;
      send_word(5'd21, 32'd2, 1'b0);
      @(negedge clock);
      @(negedge clock);
      #1;
      checks++;
      if ({verify_err, load_ready, proc_hold} !== 3'b101)
         $display("[TB] FAIL verify_err_state got %b required 101",
                  {verify_err, load_ready, proc_hold});
      else passes++;
      corrupt = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if ({verify_err, proc_hold} !== 2'b00)
         $display("[TB] FAIL verify_reset got %b required 00", {verify_err, proc_hold});
      else passes++;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
   endtask
`endif

   // Test sequence
   initial begin
      @(negedge clock);
      @(negedge clock);
      clear_model = 1'b0;
      #1;
      test_reset();
      reset = 1'b1;
      @(negedge clock);
      test_idle_passthrough();
      test_back_to_back();
      test_r0_word();
      test_proc_write_dropped();
      test_reset_mid_stream();
`ifdef REGFILE_PRELOAD_VERIFY_EN
      test_verify_mismatch();
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/regfile_preload.md
Name: regfile_preload

Overview:
- Hardware counterpart to the test harness's register read-back path: the harness reads the regfile out after a run, and this block writes initial values into it before a run.
- Sits between the processor and the regfile write port.
- While idle, it passes the processor's write port straight through.
- After a start pulse, it holds the processor, accepts a valid/ready stream of (register, value) pairs and commits each one through the regfile write port, then releases the processor.

Parameters:
- NUM_REGS, 32, number of architectural registers
- REG_W, 5, register index width
- DATA_W, 32, register data width
- CNT_W, 6, width of the accepted-write counter

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a preload; ignored unless in IDLE
- load_valid  in  1  stream word valid
- load_ready  out  1  block can accept a word this cycle
- load_reg  in  REG_W  destination register
- load_data  in  DATA_W  value to write
- load_last  in  1  marks the final word of the stream
- proc_we  in  1  processor ctrl_writeEnable
- proc_wr_reg  in  REG_W  processor ctrl_writeReg
- proc_wr_data  in  DATA_W  processor data_writeReg
- rf_we  out  1  regfile ctrl_writeEnable
- rf_wr_reg  out  REG_W  regfile ctrl_writeReg
- rf_wr_data  out  DATA_W  regfile data_writeReg
- proc_hold  out  1  stalls the processor; asserted throughout a preload
- busy  out  1  state is neither IDLE nor DONE
- done  out  1  one-cycle pulse when a preload completes
- err_r0  out  1  sticky flag: a word targeting r0 was received
- count  out  CNT_W  words accepted in the current preload

Behaviour:
- Reset (asserting edge of the active-low reset): state=IDLE; count=0; err_r0=0; done=0; proc_hold=0; load_ready=0. Regfile contents are not touched; a partial load stays in the regfile.
- IDLE:
  - rf_* = proc_* combinationally, zero latency.
  - load_ready=0.
  - start=1 -> LOAD; on that edge, count clears to 0 and err_r0 clears to 0.
- LOAD:
  - proc_hold=1 and load_ready=1.
  - proc_we is ignored; processor writes are dropped.
  - Handshake = load_valid & load_ready.
  - On a handshake: rf_we=1, rf_wr_reg=load_reg, rf_wr_data=load_data, combinationally in the same cycle, so the regfile commits on that rising edge.
  - count increments on each handshake and saturates at 2^CNT_W-1.
  - No handshake -> rf_we=0.
  - load_reg==0: rf_we forced to 0, err_r0 set (sticky), count still increments, and the state machine continues.
  - Handshake with load_last=1 -> DONE (with the optional feature enabled, via CHECK first).
  - start is ignored in every state except IDLE.
- DONE:
  - done=1 for exactly one cycle; proc_hold stays 1 in this cycle.
  - Next state is IDLE, which drops proc_hold and restores passthrough.
- Back-to-back handshakes: without the optional feature, one word per cycle is sustained.
- Duplicate register targets: the last write wins.
- Reset mid-LOAD: go to IDLE immediately; proc_hold deasserts asynchronously.

Optional Feature:
- Macro: REGFILE_PRELOAD_VERIFY_EN.
- Enabled:
  - Adds ports rd_sel (out, 1), rf_rd_reg (out, REG_W) and rf_rd_data (in, DATA_W). rd_sel muxes the regfile readRegA index away from the processor.
  - After each non-r0 handshake, go to CHECK for one cycle: load_ready=0, rd_sel=1, rf_rd_reg = latched register index.
  - In CHECK, compare rf_rd_data against the latched data:
    - match -> LOAD, or DONE if the latched last bit is set;
    - mismatch -> ERR.
  - ERR: proc_hold=1, load_ready=0, and a new verify_err output is 1. Only reset exits ERR.
  - Throughput is one word per 2 cycles.
- Disabled: no CHECK or ERR state, no extra ports, one word per cycle.

Decomposition:
- Package regfile_preload_pkg holds:
  - state encoding (IDLE, LOAD, CHECK, DONE, ERR);
  - REG_W, DATA_W and NUM_REGS constants;
  - R0 index constant.
- One natural sub-module, preload_wr_mux: the combinational IDLE/LOAD write-port select, reused for the readRegA hijack mux.

Test Plan:
- Idle passthrough: proc_we=1, proc_wr_reg=7, proc_wr_data=0x1234 -> rf_we=1, reg 7 reads 0x1234; load_ready=0.
- Three-word stream back-to-back: {r1=5, r2=-3, r31=0xDEADBEEF, last} -> regs hold those values; count=3; done pulses 1 cycle; proc_hold high from the edge after start until the cycle after done.
- r0 in stream: {r0=9, r4=4 last} -> r0 stays 0, r4=4, err_r0=1, count=2.
- Processor write during LOAD: proc_we=1, reg 4=77 mid-stream -> reg 4 keeps its streamed value; proc value dropped.
- Reset mid-stream after 1 of 3 words -> outputs at reset values; first word remains written; a following start loads cleanly with count restarting at 0.
- With REGFILE_PRELOAD_VERIFY_EN: force rf_rd_data mismatch on word 2 -> state ERR, verify_err=1, load_ready=0, proc_hold held until reset.
